// File: rtl/zoctal_ram_cfg_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zoctal_ram_cfg_seq : writes each Octal RAM mode register from a parameter
//                      table, reads it back and checks it under a mask.
// Revision: 1.0
// ----------------------------------------------------------------------------
module zoctal_ram_cfg_seq #(
   parameter int                    NUM_REGS   = 4,
   parameter logic [8*NUM_REGS-1:0] CFG_ADDR   = 32'h08060400,
   parameter logic [8*NUM_REGS-1:0] CFG_DATA   = 32'h00F04008,
   parameter logic [8*NUM_REGS-1:0] CFG_MASK   = 32'hFF00FFFF,
   parameter bit                    VERIFY_EN  = 1'b1,
   parameter int                    MAX_RETRY  = 3,
   parameter int                    RD_TIMEOUT = 255
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iStart,
   output logic       oReqValid,
   input  logic       iReqReady,
   output logic       oReqWr,
   output logic [7:0] oReqAddr,
   output logic [7:0] oReqData,
   input  logic       iRdValid,
   input  logic [7:0] iRdData,
   output logic       oBusy,
   output logic       oDone,
   output logic       oErr,
   output logic [3:0] oErrIdx,
   output logic [2:0] oRetryCnt
);

   localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);
   localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);
   localparam logic [7:0] TMO_MAX   = 8'(RD_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_RD_REQ  = 3'd2,
      S_RD_WAIT = 3'd3,
      S_NEXT    = 3'd4,
      S_DONE    = 3'd5,
      S_FAIL    = 3'd6
   } state_t;

   state_t     state;
   logic [3:0] idx;
   logic [7:0] tmo;

   // Table is always 16 deep so a 4-bit index never runs off the end.
   logic [7:0] tbl_addr [16];
   logic [7:0] tbl_data [16];
   logic [7:0] tbl_mask [16];

   for (genvar i = 0; i < 16; i++) begin : g_tbl
      if (i < NUM_REGS) begin : g_used
         assign tbl_addr[i] = CFG_ADDR[8*i +: 8];
         assign tbl_data[i] = CFG_DATA[8*i +: 8];
         assign tbl_mask[i] = CFG_MASK[8*i +: 8];
      end else begin : g_unused
         assign tbl_addr[i] = 8'h00;
         assign tbl_data[i] = 8'h00;
         assign tbl_mask[i] = 8'h00;
      end
   end

   logic [3:0] idx_nxt;
   logic [2:0] attempts_inc;
   logic       mismatch;

   always_comb begin
      idx_nxt      = (idx == 4'hF) ? idx : idx + 4'd1;
      attempts_inc = (oRetryCnt == 3'd7) ? oRetryCnt : oRetryCnt + 3'd1;
      mismatch     = |((iRdData ^ tbl_data[idx]) & tbl_mask[idx]);
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state     <= S_IDLE;
         idx       <= 4'd0;
         tmo       <= 8'd0;
         oReqValid <= 1'b0;
         oReqWr    <= 1'b0;
         oReqAddr  <= 8'h00;
         oReqData  <= 8'h00;
         oBusy     <= 1'b0;
         oDone     <= 1'b0;
         oErr      <= 1'b0;
         oErrIdx   <= 4'd0;
         oRetryCnt <= 3'd0;
      end else begin
         oDone <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (iStart) begin
                  idx       <= 4'd0;
                  oRetryCnt <= 3'd0;
                  oErr      <= 1'b0;
                  oErrIdx   <= 4'd0;
                  oBusy     <= 1'b1;
                  oReqValid <= 1'b1;
                  oReqWr    <= 1'b1;
                  oReqAddr  <= tbl_addr[0];
                  oReqData  <= tbl_data[0];
                  state     <= S_WR_REQ;
               end
            end
            S_WR_REQ: begin
               if (iReqReady) begin
                  if (VERIFY_EN) begin
                     oReqWr   <= 1'b0;
                     oReqData <= 8'h00;
                     state    <= S_RD_REQ;
                  end else begin
                     oReqValid <= 1'b0;
                     state     <= S_NEXT;
                  end
               end
            end
            S_RD_REQ: begin
               if (iReqReady) begin
                  oReqValid <= 1'b0;
                  tmo       <= 8'd0;
                  state     <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               // Data wins over the timeout when both land in the same cycle.
               if (iRdValid && !mismatch) begin
                  state <= S_NEXT;
               end else if (iRdValid || tmo == TMO_MAX) begin
                  oRetryCnt <= attempts_inc;
                  if (attempts_inc < RETRY_MAX) begin
                     oReqValid <= 1'b1;
                     oReqWr    <= 1'b1;
                     oReqAddr  <= tbl_addr[idx];
                     oReqData  <= tbl_data[idx];
                     state     <= S_WR_REQ;
                  end else begin
                     state <= S_FAIL;
                  end
               end else begin
                  tmo <= tmo + 8'd1;
               end
            end
            S_NEXT: begin
               oRetryCnt <= 3'd0;
               if (idx == LAST_IDX) begin
                  oDone <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx       <= idx_nxt;
                  oReqValid <= 1'b1;
                  oReqWr    <= 1'b1;
                  oReqAddr  <= tbl_addr[idx_nxt];
                  oReqData  <= tbl_data[idx_nxt];
                  state     <= S_WR_REQ;
               end
            end
            S_DONE: begin
               oBusy <= 1'b0;
               state <= S_IDLE;
            end
            S_FAIL: begin
               oErr      <= 1'b1;
               oErrIdx   <= idx;
               oRetryCnt <= RETRY_MAX;
               oBusy     <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
